// File: rtl/euclid_heuristic_fetch.sv
// Euclidean-distance index generator and sqrt-table requester for the A* heuristic.
// Result appears 3 edges after acceptance; it is held in RESULT until out_ready, and in_ready stays low until then.
module euclid_heuristic_fetch #(
  parameter int COORD_W = 5,
  parameter int IDX_W   = 10,
  parameter int DATA_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] node_x,
  input  logic [COORD_W-1:0] node_y,
  input  logic [COORD_W-1:0] goal_x,
  input  logic [COORD_W-1:0] goal_y,
  output logic [IDX_W-1:0]   dist_sq_index,
  input  logic [DATA_W-1:0]  sqrt_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  h_value,
  output logic               h_saturated
);

  localparam int SQ_W  = 2 * COORD_W;
  localparam int SUM_W = SQ_W + 1;
  localparam int CMP_W = (SUM_W > IDX_W) ? SUM_W : IDX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, CAPTURE, RESULT} state_t;

  state_t state, state_nxt;

  logic [COORD_W-1:0] dx, dy;
  logic [SQ_W-1:0]    dx_sq, dy_sq;
  logic [SUM_W-1:0]   dist_sq;
  logic [CMP_W-1:0]   dist_sq_ext;
  logic [CMP_W-1:0]   idx_max;
  logic [IDX_W-1:0]   idx_c;
  logic               sat_c;
  logic               sat_q;
  logic               accept;

  // Compare-and-subtract keeps the deltas unsigned without a sign bit.
  always_comb begin
    dx          = (node_x >= goal_x) ? (node_x - goal_x) : (goal_x - node_x);
    dy          = (node_y >= goal_y) ? (node_y - goal_y) : (goal_y - node_y);
    dx_sq       = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
    dy_sq       = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
    dist_sq     = {1'b0, dx_sq} + {1'b0, dy_sq};
    dist_sq_ext = CMP_W'(dist_sq);
    idx_max     = CMP_W'({IDX_W{1'b1}});
    sat_c       = (dist_sq_ext > idx_max);
    idx_c       = sat_c ? {IDX_W{1'b1}} : IDX_W'(dist_sq_ext);
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESULT;
      RESULT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == RESULT);
  end

  // The table registers the index at the end of LOOKUP, so its output is only trusted in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_sq_index <= '0;
      sat_q         <= 1'b0;
      h_value       <= '0;
      h_saturated   <= 1'b0;
    end else begin
      if (accept) begin
        dist_sq_index <= idx_c;
        sat_q         <= sat_c;
      end
      if (state == CAPTURE) begin
        h_value     <= sqrt_result;
        h_saturated <= sat_q;
      end
    end
  end

endmodule
